// File: rtl/seq_word_serializer.sv
// Parallel-to-serial word feeder for the sequence-detector stage.
// One shifting word plus a one-word holding buffer give gap-free streaming.
module seq_word_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hb_q, hb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hb_full_q, hb_full_d;

  logic             accept;
  logic             last_edge;
  logic [WIDTH-1:0] sr_shifted;

  assign accept    = in_valid && !hb_full_q;
  assign last_edge = (state_q == SHIFT) && !stall && (cnt_q == LAST_IDX);

  always_comb begin
    if (MSB_FIRST) begin
      sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
    end else begin
      sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    hb_d      = hb_q;
    cnt_d     = cnt_q;
    hb_full_d = hb_full_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (cnt_q != LAST_IDX) begin
            sr_d  = sr_shifted;
            cnt_d = cnt_q + 1'b1;
          end else if (hb_full_q) begin
            sr_d      = hb_q;
            hb_full_d = 1'b0;
            cnt_d     = '0;
          end else if (accept) begin
            sr_d  = in_data;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        // An accept not consumed by the last-bit reload parks in the buffer.
        if (accept && !last_edge) begin
          hb_d      = in_data;
          hb_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      hb_q      <= '0;
      cnt_q     <= '0;
      hb_full_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      hb_q      <= hb_d;
      cnt_q     <= cnt_d;
      hb_full_q <= hb_full_d;
    end
  end

  always_comb begin
    in_ready  = !hb_full_q;
    ser_out   = 1'b0;
    if (state_q == SHIFT) begin
      ser_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    end
    ser_valid = (state_q == SHIFT) && !stall;
    word_last = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    busy      = (state_q == SHIFT) || hb_full_q;
  end

endmodule

// File: doc/seq_word_serializer.md
# seq_word_serializer

Upstream feeder for the serial sequence-detector stage. It accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial output, which the detector samples each cycle. A one-word holding buffer lets consecutive words stream with no idle bit between them. A stall input pauses the bit stream without losing data.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word to send.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- stall  input  1  when high, freeze the bit stream this cycle.
- ser_out  output  1  serial bit to the detector's `in`.
- ser_valid  output  1  ser_out carries a live bit this cycle.
- word_last  output  1  high while the last bit of a word is presented.
- busy  output  1  a word is shifting or buffered.

## Operation
- Internal state:
  - sr: shift register, WIDTH bits.
  - cnt: bit index, $clog2(WIDTH) bits.
  - hb: holding buffer, WIDTH bits.
  - hb_full: holding-buffer flag.
  - FSM with two states, IDLE and SHIFT.
- Accept: a word is taken when in_valid && in_ready at a rising edge. in_ready = !hb_full and is a function of registers only. in_data need not stay stable after acceptance.
- IDLE:
  - On accept, load sr from in_data, clear cnt, and go to SHIFT. The word bypasses hb.
- SHIFT:
  - If stall=0 and cnt<WIDTH-1: shift sr by one toward the output end and increment cnt.
  - If stall=0 and cnt==WIDTH-1 (last-bit edge), reload as follows:
    - hb_full: move hb to sr, clear hb_full, clear cnt, stay in SHIFT.
    - hb empty and an accept occurs this edge: load in_data directly into sr, clear cnt, stay in SHIFT.
    - Otherwise: go to IDLE.
  - Any other accept while in SHIFT writes hb and sets hb_full.
  - If stall=1: sr, cnt and the FSM state hold. Accepts into hb are still allowed.
- Outputs:
  - ser_out = sr[WIDTH-1] (MSB_FIRST=1) or sr[0] (MSB_FIRST=0) while in SHIFT; 0 in IDLE.
  - ser_valid = (state==SHIFT) && !stall.
  - word_last = (state==SHIFT) && cnt==WIDTH-1.
  - busy = (state==SHIFT) || hb_full.
- Bits leave in exact word order. No word is dropped or duplicated.
- Reset (rst=0, at any time, including mid-word): state=IDLE, sr=0, hb=0, cnt=0, hb_full=0. Any partially sent word and any buffered word are discarded.
- Outputs during and immediately after reset: in_ready=1, ser_out=0, ser_valid=0, word_last=0, busy=0.

## Timing
- Latency: a word accepted at edge k presents its first bit on ser_out in the cycle after edge k. Bit i is presented in the i-th unstalled SHIFT cycle.
- Throughput: 1 bit/clock. Continuous streaming requires the next word to be accepted before the current word's last-bit edge.
- Backpressure:
  - in_ready drops the cycle after hb fills.
  - in_ready rises the cycle after the last-bit edge that drains hb.
- Simultaneous events at the last-bit edge:
  - With hb_full, in_ready is low, so no accept can collide with the reload.
  - With hb empty, an accept at that same edge goes straight into sr with no bubble.
- stall changes take effect in the same cycle: ser_valid falls combinationally and the shift is suppressed at the next edge.
- The reset de-assertion edge performs no accept.

## Test plan
- Single word: WIDTH=8, MSB_FIRST=1, send 8'hA5 with stall=0.
  - ser_out = 1,0,1,0,0,1,0,1 over 8 consecutive ser_valid cycles.
  - word_last is high only on the 8th bit.
  - The FSM is in IDLE, with busy=0, on the cycle after the 8th bit.
- Back-to-back: send 8'hCA then 8'h5A, with the second word offered while the first is shifting.
  - 16 contiguous valid bits: 1100101001011010.
  - No gap between words.
  - in_ready is low while hb holds 8'h5A.
- Backpressure: hold in_valid=1 with 3 words 8'h01, 8'h02, 8'h03.
  - The third word is accepted only after the first word's last-bit edge.
  - The serial stream equals the concatenation of the three words.
- Stall: assert stall for 3 cycles in the middle of word 8'hF0, after the 2nd bit.
  - ser_valid=0 for exactly those 3 cycles.
  - The bit sequence resumes at bit 3 unchanged.
  - The total bit count is still 8.
- Reset mid-word: pull rst low after 4 bits of 8'hFF, with hb holding 8'h0F.
  - Immediately: ser_out=0, ser_valid=0, in_ready=1, busy=0.
  - After release, no residual bits are emitted.
- LSB-first: MSB_FIRST=0, send 8'h0A.
  - ser_out = 0,1,0,1,0,0,0,0.
  - Feeding this into the detector produces one 1010 match.
